nn_param_mem: RTL and testbench



---
 rtl/nn_mem_pkg.sv | 8 +
 rtl/nn_param_mem_if.sv | 16 +
 rtl/nn_param_sram.sv | 21 ++
 rtl/nn_param_mem.sv | 108 ++++++++++
 tb/tb_nn_param_mem.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/nn_mem_pkg.sv
// Shared constants and types for the network parameter memory.
package nn_mem_pkg;
  localparam logic [15:0] WEIGHTS_BASE_ADDRESS = 16'h0100;
  localparam logic [15:0] BIASES_BASE_ADDRESS  = 16'h0200;
  localparam int          DATA_W               = 32;

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
endpackage

// File: rtl/nn_param_mem_if.sv
// MMU single-word request/acknowledge bus between the training datapath and parameter storage.
interface nn_param_mem_if;
  import nn_mem_pkg::*;
  logic              mmu_req_i;
  logic              mmu_we_i;
  logic [31:0]       mmu_adr_i;
  logic [DATA_W-1:0] mmu_dat_i;
  logic [DATA_W-1:0] mmu_dat_o;
  logic              mmu_ack_o;
  logic              mmu_err_o;

  modport master (output mmu_req_i, mmu_we_i, mmu_adr_i, mmu_dat_i,
                  input  mmu_dat_o, mmu_ack_o, mmu_err_o);
  modport slave  (input  mmu_req_i, mmu_we_i, mmu_adr_i, mmu_dat_i,
                  output mmu_dat_o, mmu_ack_o, mmu_err_o);
endinterface

// File: rtl/nn_param_sram.sv
// Single-port synchronous word array with registered read; contents are not reset.
module nn_param_sram
  import nn_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/nn_param_mem.sv
// Weight/bias parameter store: clears both arrays after reset, then serves one
// MMU word request per two cycles with a single-cycle ack and an unmapped-address error.
module nn_param_mem
  import nn_mem_pkg::*;
#(
  parameter int WEIGHT_WORDS = 256,
  parameter int BIAS_WORDS   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  nn_param_mem_if.slave  mmu,
  output logic           init_busy_o,
  output logic [15:0]    wr_count_o
);
  localparam int WAW   = (WEIGHT_WORDS > 1) ? $clog2(WEIGHT_WORDS) : 1;
  localparam int BAW   = (BIAS_WORDS > 1) ? $clog2(BIAS_WORDS) : 1;
  localparam int TOTAL = WEIGHT_WORDS + BIAS_WORDS;

  state_t            state, state_nxt;
  logic [9:0]        clr_cnt;
  logic [15:0]       adr_lo;
  logic              upper_zero, w_hit, b_hit, accept, clr_w;
  logic              rd_w_q, rd_b_q, err_q;
  logic              w_we, w_re, b_we, b_re;
  logic [WAW-1:0]    w_addr;
  logic [BAW-1:0]    b_addr;
  logic [DATA_W-1:0] wdata, w_rdata, b_rdata;

  assign adr_lo     = mmu.mmu_adr_i[15:0];
  assign upper_zero = (mmu.mmu_adr_i[31:16] == 16'h0);
  // 17-bit compares keep base+size from wrapping when a region spans a full 256 words
  assign w_hit = upper_zero && (adr_lo >= WEIGHTS_BASE_ADDRESS) &&
                 ({1'b0, adr_lo} < ({1'b0, WEIGHTS_BASE_ADDRESS} + 17'(WEIGHT_WORDS)));
  assign b_hit = upper_zero && (adr_lo >= BIASES_BASE_ADDRESS) &&
                 ({1'b0, adr_lo} < ({1'b0, BIASES_BASE_ADDRESS} + 17'(BIAS_WORDS)));

  assign accept = (state == IDLE) && mmu.mmu_req_i;
  assign clr_w  = (clr_cnt < 10'(WEIGHT_WORDS));

  // During INIT the clear counter owns both array ports
  always_comb begin
    w_we   = 1'b0;
    w_re   = 1'b0;
    b_we   = 1'b0;
    b_re   = 1'b0;
    wdata  = mmu.mmu_dat_i;
    w_addr = WAW'(adr_lo - WEIGHTS_BASE_ADDRESS);
    b_addr = BAW'(adr_lo - BIASES_BASE_ADDRESS);
    if (state == INIT) begin
      wdata  = '0;
      w_addr = WAW'(clr_cnt);
      b_addr = BAW'(clr_cnt - 10'(WEIGHT_WORDS));
      w_we   = clr_w;
      b_we   = !clr_w;
    end else if (accept) begin
      w_we = w_hit && mmu.mmu_we_i;
      w_re = w_hit && !mmu.mmu_we_i;
      b_we = b_hit && mmu.mmu_we_i;
      b_re = b_hit && !mmu.mmu_we_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_cnt == 10'(TOTAL - 1)) state_nxt = IDLE;
      IDLE:    if (mmu.mmu_req_i) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      clr_cnt    <= '0;
      rd_w_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_count_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + 10'd1;
      if (accept) begin
        rd_w_q <= w_hit && !mmu.mmu_we_i;
        rd_b_q <= b_hit && !mmu.mmu_we_i;
        err_q  <= !(w_hit || b_hit);
        if ((w_hit || b_hit) && mmu.mmu_we_i && (wr_count_o != 16'hFFFF))
          wr_count_o <= wr_count_o + 16'd1;
      end
    end
  end

  assign init_busy_o   = (state == INIT);
  assign mmu.mmu_ack_o = (state == RESP);
  assign mmu.mmu_err_o = (state == RESP) && err_q;
  assign mmu.mmu_dat_o = (state != RESP) ? '0 :
                         rd_w_q ? w_rdata :
                         rd_b_q ? b_rdata : '0;

  nn_param_sram #(.DEPTH(WEIGHT_WORDS), .AW(WAW)) u_weights (
    .clk(clk), .we(w_we), .re(w_re), .addr(w_addr), .wdata(wdata), .rdata(w_rdata)
  );

  nn_param_sram #(.DEPTH(BIAS_WORDS), .AW(BAW)) u_biases (
    .clk(clk), .we(b_we), .re(b_re), .addr(b_addr), .wdata(wdata), .rdata(b_rdata)
  );
endmodule

// File: tb/tb_nn_param_mem.sv
// Directed bench for nn_param_mem: clear timing, weight/bias access, decode errors, held requests, reset mid-transfer.
module tb_nn_param_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] wcnt;
  int          checks = 0;
  int          failures = 0;

  nn_param_mem_if bus();

  nn_param_mem #(.WEIGHT_WORDS(256), .BIAS_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .mmu(bus), .init_busy_o(busy), .wr_count_o(wcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] d, output logic e, output int lat);
    bus.mmu_req_i = 1'b1;
    bus.mmu_we_i  = we;
    bus.mmu_adr_i = adr;
    bus.mmu_dat_i = dat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!bus.mmu_ack_o && lat < 400);
    d = bus.mmu_dat_o;
    e = bus.mmu_err_o;
    bus.mmu_req_i = 1'b0;
    step();
    chk("ack_width", 32'(bus.mmu_ack_o), 32'd0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, n, acks;
    logic [9:0]  pat;

    bus.mmu_req_i = 1'b0;
    bus.mmu_we_i  = 1'b0;
    bus.mmu_adr_i = '0;
    bus.mmu_dat_i = '0;

    step();
    step();
    chk("rst_ack",  32'(bus.mmu_ack_o), 32'd0);
    chk("rst_err",  32'(bus.mmu_err_o), 32'd0);
    chk("rst_dat",  bus.mmu_dat_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wcnt", 32'(wcnt), 32'd0);

    rst_n = 1'b1;
    wait_init(n);
    chk("init_cycles", n, 288);

    xfer(1'b0, 32'h0000_0100, 32'h0, d, e, lat);
    chk("rd100_lat", lat, 1);
    chk("rd100_dat", d, 32'h0);
    chk("rd100_err", 32'(e), 32'd0);

    xfer(1'b1, 32'h0000_0105, 32'hDEAD_BEEF, d, e, lat);
    chk("wr105_lat", lat, 1);
    chk("wr105_err", 32'(e), 32'd0);
    xfer(1'b0, 32'h0000_0105, 32'h0, d, e, lat);
    chk("rd105_dat", d, 32'hDEAD_BEEF);
    chk("wcnt_1",    32'(wcnt), 32'd1);

    xfer(1'b1, 32'h0000_021F, 32'h1234_5678, d, e, lat);
    xfer(1'b0, 32'h0000_021F, 32'h0, d, e, lat);
    chk("rd21f_dat", d, 32'h1234_5678);
    chk("rd21f_err", 32'(e), 32'd0);
    chk("wcnt_2",    32'(wcnt), 32'd2);

    xfer(1'b1, 32'h0000_0220, 32'h5555_5555, d, e, lat);
    chk("wr220_err", 32'(e), 32'd1);
    chk("wr220_wcnt", 32'(wcnt), 32'd2);
    xfer(1'b0, 32'h0000_0220, 32'h0, d, e, lat);
    chk("rd220_dat", d, 32'h0);
    chk("rd220_err", 32'(e), 32'd1);

    xfer(1'b1, 32'h0001_0100, 32'hAAAA_AAAA, d, e, lat);
    chk("wr_hi_err", 32'(e), 32'd1);
    xfer(1'b0, 32'h0000_0100, 32'h0, d, e, lat);
    chk("rd100_nochg", d, 32'h0);
    chk("rd100_nochg_err", 32'(e), 32'd0);
    chk("wcnt_hi", 32'(wcnt), 32'd2);

    // request held through the whole clear and beyond
    rst_n = 1'b0;
    bus.mmu_req_i = 1'b1;
    bus.mmu_we_i  = 1'b0;
    bus.mmu_adr_i = 32'h0000_0105;
    step();
    rst_n = 1'b1;
    acks = 0;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
      if (bus.mmu_ack_o) acks++;
    end
    chk("held_init_acks", acks, 0);
    chk("held_init_wcnt", 32'(wcnt), 32'd0);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = bus.mmu_ack_o;
      if (i == 0) chk("held_reclear_dat", bus.mmu_dat_o, 32'h0);
    end
    chk("held_ack_pattern", 32'(pat), 32'h155);
    bus.mmu_req_i = 1'b0;
    step();

    // reset during RESP of a write
    bus.mmu_req_i = 1'b1;
    bus.mmu_we_i  = 1'b1;
    bus.mmu_adr_i = 32'h0000_0100;
    bus.mmu_dat_i = 32'h0000_0001;
    step();
    chk("rsp_wcnt_pre", 32'(wcnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsp_rst_ack",  32'(bus.mmu_ack_o), 32'd0);
    chk("rsp_rst_busy", 32'(busy), 32'd1);
    chk("rsp_rst_wcnt", 32'(wcnt), 32'd0);
    bus.mmu_req_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    acks = 0;
    n = 0;
    while (busy && n < 400) begin
      step();
      n++;
      if (bus.mmu_ack_o) acks++;
    end
    chk("rsp_no_ack", acks, 0);
    chk("rsp_init_cycles", n, 288);
    xfer(1'b0, 32'h0000_0100, 32'h0, d, e, lat);
    chk("rsp_rd100_dat", d, 32'h0);
    chk("rsp_wcnt", 32'(wcnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
